// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing constants: default 640x480 @ 60 Hz porch/sync/display
// values, derived line/frame totals, the coordinate bus width and a small
// range-decode helper used for the sync windows.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Coordinate bus width; both totals must fit below COORD_LIMIT.
    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    // Default timing set (pixel clock = 100 MHz / 4 = 25 MHz).
    localparam int CLK_DIV_DEF   = 4;
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // True when lo <= v <= hi (inclusive window decode).
    function automatic logic in_range(input logic [COORD_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// -----------------------------------------------------------------------------
// pixel_tick_div
// Board-clock to pixel-rate divider. A counter runs 0..CLK_DIV-1 and wraps;
// p_tick is high for the one clk cycle in which the counter sits at its
// terminal value.
//
// Ports:
//   clk    in  board clock
//   reset  in  synchronous, active-high; counter returns to 0
//   p_tick out one-clk strobe per pixel period (combinational decode)
// -----------------------------------------------------------------------------
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign p_tick = (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q + 1'b1;
        if (p_tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator (default 640x480 @ ~59.5 Hz from a 100 MHz clock).
// Pixel/line counters advance once per p_tick; hsync/vsync are registered
// from the next-state counters so they line up with the x/y they belong to.
//
// Ports:
//   clk        in   board clock
//   reset      in   synchronous, active-high
//   x          out  horizontal count, 0..H_TOTAL-1
//   y          out  vertical count, 0..V_TOTAL-1
//   video_on   out  high while x < H_DISPLAY and y < V_DISPLAY
//   hsync      out  active-low horizontal sync, registered
//   vsync      out  active-low vertical sync, registered
//   p_tick     out  one-clk strobe per pixel period
//   frame_tick out  (only with VGA_SYNC_FRAME_TICK_EN) one-clk pulse on the
//                   first cycle of (0,0) after a frame wrap
//
// Optional feature macro: VGA_SYNC_FRAME_TICK_EN
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               p_tick
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    output logic               frame_tick
`endif
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

    // Totals that do not fit the coordinate bus are refused at elaboration.
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_end;

    assign line_end = p_tick && (x_q == X_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Decoding the next-state counters lets the registered sync change on the
    // same edge as the coordinate that enters/leaves the sync window.
    assign hsync_d = ~in_range(x_d, HS_START, HS_END);
    assign vsync_d = ~in_range(y_d, VS_START, VS_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = (int'(x_q) < H_DISPLAY) && (int'(y_q) < V_DISPLAY);

`ifdef VGA_SYNC_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Set on the edge that wraps (last x, last y) -> (0,0), so the pulse
    // occupies exactly the first (0,0) clk cycle; reset clears it so reset
    // release never produces a pulse.
    assign frame_tick_d = line_end && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    logic unused_line_end;
    assign unused_line_end = line_end;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench. DUT A uses the default 640x480 timing; DUT B uses a tiny
// timing set (CLK_DIV=2, 16x12 totals, hsync x in [10,12], vsync y in [8,9],
// visible 8x6) so whole frames fit in a short run.
// Expected values are closed-form functions of the edge count n since reset
// release: div = n % CLK_DIV, pixel = n / CLK_DIV, x = pixel % H_TOTAL,
// y = (pixel / H_TOTAL) % V_TOTAL.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       vo_a, hs_a, vs_a, pt_a;
    logic       vo_b, hs_b, vs_b, pt_b;
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic       ft_a, ft_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_a (
        .clk     (clk),
        .reset   (rst_a),
        .x       (x_a),
        .y       (y_a),
        .video_on(vo_a),
        .hsync   (hs_a),
        .vsync   (vs_a),
        .p_tick  (pt_a)
`ifdef VGA_SYNC_FRAME_TICK_EN
        ,
        .frame_tick(ft_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV  (2),
        .H_DISPLAY(8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (3),
        .V_DISPLAY(6),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (2)
    ) u_dut_b (
        .clk     (clk),
        .reset   (rst_b),
        .x       (x_b),
        .y       (y_b),
        .video_on(vo_b),
        .hsync   (hs_b),
        .vsync   (vs_b),
        .p_tick  (pt_b)
`ifdef VGA_SYNC_FRAME_TICK_EN
        ,
        .frame_tick(ft_b)
`endif
    );

    // Hold reset 3 cycles, release at a negedge; caller then counts edges.
    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (x_a !== 10'd0) begin n_bad++; $display("FAIL rst_x: got %0d, expected 0", x_a); end
        n_cmp++; if (y_a !== 10'd0) begin n_bad++; $display("FAIL rst_y: got %0d, expected 0", y_a); end
        n_cmp++; if (hs_a !== 1'b1) begin n_bad++; $display("FAIL rst_hsync: got %b, expected 1", hs_a); end
        n_cmp++; if (vs_a !== 1'b1) begin n_bad++; $display("FAIL rst_vsync: got %b, expected 1", vs_a); end
        n_cmp++; if (vo_a !== 1'b1) begin n_bad++; $display("FAIL rst_video_on: got %b, expected 1", vo_a); end
        n_cmp++; if (pt_a !== 1'b0) begin n_bad++; $display("FAIL rst_p_tick: got %b, expected 0", pt_a); end
`ifdef VGA_SYNC_FRAME_TICK_EN
        n_cmp++; if (ft_a !== 1'b0) begin n_bad++; $display("FAIL rst_frame_tick: got %b, expected 0", ft_a); end
`endif
        rst_a = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            n_cmp++; if (pt_a !== 1'b0) begin n_bad++; $display("FAIL early_p_tick n=%0d: got %b, expected 0", n, pt_a); end
        end
        @(negedge clk);
        n_cmp++; if (pt_a !== 1'b1) begin n_bad++; $display("FAIL first_p_tick: got %b, expected 1", pt_a); end
        n_cmp++; if (x_a !== 10'd0) begin n_bad++; $display("FAIL x_before_tick: got %0d, expected 0", x_a); end
        @(negedge clk);
        n_cmp++; if (x_a !== 10'd1) begin n_bad++; $display("FAIL x_after_tick: got %0d, expected 1", x_a); end
        n_cmp++; if (pt_a !== 1'b0) begin n_bad++; $display("FAIL p_tick_after: got %b, expected 0", pt_a); end
        $display("txn reset: x=%0d y=%0d hsync=%b vsync=%b", x_a, y_a, hs_a, vs_a);
    endtask

    // Continues from test_reset (4 edges since release) for 10000 cycles.
    task automatic test_pixel_tick();
        int   e_tick = 0, e_xy = 0, e_hold = 0, e_sync = 0, e_vo = 0;
        int   ex, ey;
        logic prev_pt;
        logic [9:0] prev_x, prev_y;
        prev_pt = pt_a; prev_x = x_a; prev_y = y_a;
        for (int n = 5; n <= 10004; n++) begin
            @(negedge clk);
            ex = (n / 4) % 800;
            ey = (n / 3200) % 525;
            if (pt_a !== ((n % 4) == 3)) e_tick++;
            if (int'(x_a) != ex || int'(y_a) != ey) e_xy++;
            if (!prev_pt && (x_a !== prev_x || y_a !== prev_y)) e_hold++;
            if (hs_a !== !(ex >= 656 && ex <= 751) || vs_a !== 1'b1) e_sync++;
            if (vo_a !== (ex < 640 && ey < 480)) e_vo++;
            prev_pt = pt_a; prev_x = x_a; prev_y = y_a;
        end
        n_cmp++; if (e_tick != 0) begin n_bad++; $display("FAIL tick_cadence: got %0d bad cycles, expected 0", e_tick); end
        n_cmp++; if (e_xy != 0) begin n_bad++; $display("FAIL xy_sequence: got %0d bad cycles, expected 0", e_xy); end
        n_cmp++; if (e_hold != 0) begin n_bad++; $display("FAIL xy_hold_non_tick: got %0d changes, expected 0", e_hold); end
        n_cmp++; if (e_sync != 0) begin n_bad++; $display("FAIL sync_track: got %0d bad cycles, expected 0", e_sync); end
        n_cmp++; if (e_vo != 0) begin n_bad++; $display("FAIL video_on_track: got %0d bad cycles, expected 0", e_vo); end
        $display("txn pixel_tick: 10000 cycles, end x=%0d y=%0d", x_a, y_a);
    endtask

    task automatic test_hsync();
        int vo_fall = -1, hs_fall = -1, hs_rise = -1, hs_low = 0;
        int x_at_fall = -1, x_before_fall = -1;
        int x_wrap = -1, y_wrap = -1;
        reset_a();
        for (int n = 1; n <= 3200; n++) begin
            @(negedge clk);
            if (vo_a === 1'b0 && vo_fall < 0) begin
                vo_fall = n; x_at_fall = int'(x_a);
            end
            if (n == 2559) x_before_fall = int'(x_a);
            if (hs_a === 1'b0) begin
                hs_low++;
                if (hs_fall < 0) hs_fall = n;
            end else if (hs_fall >= 0 && hs_rise < 0) begin
                hs_rise = n;
            end
            if (n == 3200) begin x_wrap = int'(x_a); y_wrap = int'(y_a); end
        end
        n_cmp++; if (vo_fall != 2560) begin n_bad++; $display("FAIL video_on_fall_cycle: got %0d, expected 2560", vo_fall); end
        n_cmp++; if (x_at_fall != 640) begin n_bad++; $display("FAIL video_on_fall_x: got %0d, expected 640", x_at_fall); end
        n_cmp++; if (x_before_fall != 639) begin n_bad++; $display("FAIL x_before_fall: got %0d, expected 639", x_before_fall); end
        n_cmp++; if (hs_fall != 2624) begin n_bad++; $display("FAIL hsync_fall_cycle: got %0d, expected 2624", hs_fall); end
        n_cmp++; if (hs_rise != 3008) begin n_bad++; $display("FAIL hsync_rise_cycle: got %0d, expected 3008", hs_rise); end
        n_cmp++; if (hs_low != 384) begin n_bad++; $display("FAIL hsync_low_cycles: got %0d, expected 384", hs_low); end
        n_cmp++; if (x_wrap != 0) begin n_bad++; $display("FAIL line_wrap_x: got %0d, expected 0", x_wrap); end
        n_cmp++; if (y_wrap != 1) begin n_bad++; $display("FAIL line_wrap_y: got %0d, expected 1", y_wrap); end
        $display("txn hsync: low=%0d fall=%0d rise=%0d", hs_low, hs_fall, hs_rise);
    endtask

    task automatic test_vsync_frame();
        int e_xy = 0, e_sync = 0, e_vo = 0, e_tick = 0;
        int vs_fall = -1, vs_rise = -1, vs_low = 0, x_at_vs_fall = -1, x_at_vs_rise = -1;
        int x383 = -1, y383 = -1, x384 = -1, y384 = -1;
        int ex, ey;
`ifdef VGA_SYNC_FRAME_TICK_EN
        int ft_cnt = 0, ft_first = -1, ft_second = -1;
`endif
        reset_b();
        for (int n = 1; n <= 800; n++) begin
            @(negedge clk);
            ex = (n / 2) % 16;
            ey = (n / 32) % 12;
            if (int'(x_b) != ex || int'(y_b) != ey) e_xy++;
            if (hs_b !== !(ex >= 10 && ex <= 12) || vs_b !== !(ey >= 8 && ey <= 9)) e_sync++;
            if (vo_b !== (ex < 8 && ey < 6)) e_vo++;
            if (pt_b !== ((n % 2) == 1)) e_tick++;
            if (n <= 384 && vs_b === 1'b0) begin
                vs_low++;
                if (vs_fall < 0) begin vs_fall = n; x_at_vs_fall = int'(x_b); end
            end else if (vs_fall >= 0 && vs_rise < 0) begin
                vs_rise = n; x_at_vs_rise = int'(x_b);
            end
            if (n == 383) begin x383 = int'(x_b); y383 = int'(y_b); end
            if (n == 384) begin x384 = int'(x_b); y384 = int'(y_b); end
`ifdef VGA_SYNC_FRAME_TICK_EN
            if (ft_b === 1'b1) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = n; else if (ft_second < 0) ft_second = n;
            end
`endif
        end
        n_cmp++; if (e_xy != 0) begin n_bad++; $display("FAIL small_xy_sequence: got %0d bad cycles, expected 0", e_xy); end
        n_cmp++; if (e_sync != 0) begin n_bad++; $display("FAIL small_sync_track: got %0d bad cycles, expected 0", e_sync); end
        n_cmp++; if (e_vo != 0) begin n_bad++; $display("FAIL small_video_on: got %0d bad cycles, expected 0", e_vo); end
        n_cmp++; if (e_tick != 0) begin n_bad++; $display("FAIL small_tick: got %0d bad cycles, expected 0", e_tick); end
        n_cmp++; if (vs_fall != 256) begin n_bad++; $display("FAIL vsync_fall_cycle: got %0d, expected 256", vs_fall); end
        n_cmp++; if (vs_rise != 320) begin n_bad++; $display("FAIL vsync_rise_cycle: got %0d, expected 320", vs_rise); end
        n_cmp++; if (vs_low != 64) begin n_bad++; $display("FAIL vsync_low_cycles: got %0d, expected 64", vs_low); end
        n_cmp++; if (x_at_vs_fall != 0 || x_at_vs_rise != 0) begin n_bad++; $display("FAIL vsync_edge_x: got %0d/%0d, expected 0/0", x_at_vs_fall, x_at_vs_rise); end
        n_cmp++; if (x383 != 15 || y383 != 11) begin n_bad++; $display("FAIL frame_last_pixel: got (%0d,%0d), expected (15,11)", x383, y383); end
        n_cmp++; if (x384 != 0 || y384 != 0) begin n_bad++; $display("FAIL frame_wrap: got (%0d,%0d), expected (0,0)", x384, y384); end
`ifdef VGA_SYNC_FRAME_TICK_EN
        n_cmp++; if (ft_cnt != 2) begin n_bad++; $display("FAIL frame_tick_count: got %0d, expected 2", ft_cnt); end
        n_cmp++; if (ft_first != 384) begin n_bad++; $display("FAIL frame_tick_first: got %0d, expected 384", ft_first); end
        n_cmp++; if (ft_second - ft_first != 384) begin n_bad++; $display("FAIL frame_tick_period: got %0d, expected 384", ft_second - ft_first); end
`endif
        $display("txn vsync_frame: vs_low=%0d fall=%0d rise=%0d", vs_low, vs_fall, vs_rise);
    endtask

    task automatic test_reset_mid();
        // Default timing: (700, 0) with hsync low, mid-pixel (div = 1).
        reset_a();
        repeat (2801) @(negedge clk);
        n_cmp++; if (x_a !== 10'd700 || hs_a !== 1'b0) begin n_bad++; $display("FAIL mid_a_setup: got x=%0d hs=%b, expected x=700 hs=0", x_a, hs_a); end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_cmp++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_bad++; $display("FAIL mid_a_xy: got (%0d,%0d), expected (0,0)", x_a, y_a); end
        n_cmp++; if (hs_a !== 1'b1 || vo_a !== 1'b1 || pt_a !== 1'b0) begin n_bad++; $display("FAIL mid_a_outs: got hs=%b vo=%b pt=%b, expected 1 1 0", hs_a, vo_a, pt_a); end
        repeat (2) @(negedge clk);
        n_cmp++; if (pt_a !== 1'b0) begin n_bad++; $display("FAIL mid_a_div_early: got p_tick=%b, expected 0", pt_a); end
        @(negedge clk);
        n_cmp++; if (pt_a !== 1'b1 || x_a !== 10'd0) begin n_bad++; $display("FAIL mid_a_div_restart: got pt=%b x=%0d, expected pt=1 x=0", pt_a, x_a); end
        // Small timing: (11, 8) with both syncs low.
        reset_b();
        repeat (278) @(negedge clk);
        n_cmp++; if (x_b !== 10'd11 || y_b !== 10'd8 || hs_b !== 1'b0 || vs_b !== 1'b0) begin n_bad++; $display("FAIL mid_b_setup: got (%0d,%0d) hs=%b vs=%b, expected (11,8) 0 0", x_b, y_b, hs_b, vs_b); end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        n_cmp++; if (x_b !== 10'd0 || y_b !== 10'd0 || hs_b !== 1'b1 || vs_b !== 1'b1) begin n_bad++; $display("FAIL mid_b_reset: got (%0d,%0d) hs=%b vs=%b, expected (0,0) 1 1", x_b, y_b, hs_b, vs_b); end
`ifdef VGA_SYNC_FRAME_TICK_EN
        n_cmp++; if (ft_b !== 1'b0) begin n_bad++; $display("FAIL mid_b_frame_tick: got %b, expected 0", ft_b); end
`endif
        $display("txn reset_mid: a=(%0d,%0d) b=(%0d,%0d)", x_a, y_a, x_b, y_b);
    endtask

    initial begin
        test_reset();
        test_pixel_tick();
        test_hsync();
        test_vsync_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. Drives the pixel coordinate bus (`x`, `y`) and `video_on` consumed by the text/graphics renderers, and the `hsync`/`vsync` pins to the VGA connector. Renderers produce `rgb` from this block's outputs.

## Interface
Parameters:
- `CLK_DIV`, 4: board clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- `clk`, in, 1: board clock, 100 MHz.
- `reset`, in, 1: synchronous, active-high.
- `x`, out, 10: current horizontal count, 0..H_TOTAL-1.
- `y`, out, 10: current vertical count, 0..V_TOTAL-1.
- `video_on`, out, 1: high while x < H_DISPLAY and y < V_DISPLAY.
- `hsync`, out, 1: horizontal sync, active-low, registered.
- `vsync`, out, 1: vertical sync, active-low, registered.
- `p_tick`, out, 1: one-`clk` strobe, once per pixel period.
- `frame_tick`, out, 1: present only with `VGA_SYNC_FRAME_TICK_EN` (see Configuration).

## Operation
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800. V_TOTAL = 525. Both totals must be ≤ 1024; a parameter set that violates this is rejected at elaboration.
- Divider:
  - Counter `div` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (div == CLK_DIV-1), decoded combinationally.
- Horizontal counter `x`:
  - Advances only on cycles where `p_tick` is high.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `y`:
  - Advances only when `p_tick` is high and x == H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0.
  - x and y wrap in the same cycle at (799, 524) → (0, 0).
- Sync regions:
  - `hsync` is low for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` is low for y in [490, 491].
  - Both are registered from the next-state counter values, so each is aligned with the `x`/`y` values it belongs to, with no extra latency.
- `video_on`: combinational decode of the registered `x`/`y`.
- Reset values:
  - div = 0, x = 0, y = 0.
  - hsync = 1, vsync = 1.
  - `video_on` = 1, because (0,0) is visible.
  - `p_tick` = 0.
  - `frame_tick` = 0.
- Reset mid-frame: all state returns to the reset values on the next `clk` edge. No partial line or frame completes.

## Timing
- Latency:
  - First `p_tick` occurs on the 4th `clk` cycle after `reset` deasserts (div = 3).
  - `x` becomes 1 on the following edge.
- Pixel period: 4 `clk` cycles. Line: 3200 `clk` cycles. Frame: 1,680,000 `clk` cycles, about 59.5 Hz.
- Renderer handoff: consumers sample `x`/`y` as stable for 4 `clk` cycles. Synchronous-ROM consumers see data one `clk` later, which stays within the same pixel period.
- Sync edges:
  - hsync falls on the edge where x goes 655→656 and rises on 751→752.
  - vsync falls on the edge where y goes 489→490 and rises on 491→492. Both vsync edges coincide with an x 799→0 edge.

## Configuration
- `VGA_SYNC_FRAME_TICK_EN` defined:
  - Adds output `frame_tick`, registered.
  - `frame_tick` is high for exactly one `clk` cycle, the cycle in which (x, y) first equals (0,0) after a wrap from (799, 524).
  - It is not asserted at reset release.
- `VGA_SYNC_FRAME_TICK_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `vga_timing_pkg`:
  - Default porch/sync/display constants.
  - Derived H_TOTAL/V_TOTAL.
  - Coordinate width constant (10).
- Sub-module `pixel_tick_div`:
  - Parameter `CLK_DIV`; ports `clk`, `reset`, `p_tick`.
  - Contains the divider only.
- `vga_sync_gen` contains the counters, sync decode/registers, `video_on`, and the optional `frame_tick`.

## Test plan
- Reset release: hold `reset` for 3 cycles, then release → x = 0, y = 0, hsync = 1, vsync = 1, `video_on` = 1. First `p_tick` appears 4 cycles after release; then x = 1.
- Horizontal sync:
  - Run one line → `video_on` falls when x goes 639→640.
  - hsync is low for x = 656..751, exactly 384 `clk` cycles.
  - x wraps 799→0 and y increments to 1.
- Vertical sync: run to y = 489 → vsync falls when y = 490, x = 0, and rises at y = 492. Low duration is 6400 `clk` cycles.
- Frame wrap: run to (799, 524) → the next pixel is (0,0). With `VGA_SYNC_FRAME_TICK_EN`, `frame_tick` is a single 1-cycle pulse there. Frame period is 1,680,000 cycles.
- Reset mid-operation: assert `reset` for one cycle at (700, 300) with hsync low → the next edge gives x = 0, y = 0, hsync = 1, div = 0.
- Pixel-tick regularity: over 10,000 cycles → `p_tick` is high exactly every 4th cycle, and x/y never change on a non-tick cycle.
